// File: rtl/cfu_seq_pkg.sv
// cfu_seq_pkg: shared state encoding and constants for the CFU command sequencer
package cfu_seq_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_e;
    localparam logic [6:0]  STATUS_F7   = 7'h7F;
    localparam logic [31:0] TIMEOUT_RET = 32'hDEAD_BEEF;
    localparam int          F7_MSB      = 9;
    localparam int          F7_LSB      = 3;
endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter; expire flags the last cycle of a count while enabled
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign cnt_d    = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    assign expire_o = en_i && cnt_q == '0;
    // Counter register; parks at zero once the count is spent
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/cfu_cmd_sequencer.sv
// cfu_cmd_sequencer: one-at-a-time CFU command handler driving the conv1d engine
module cfu_cmd_sequencer
    import cfu_seq_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         FIXED_LAT = 1,
    parameter logic [6:0] LONG_MIN  = 7'd8,
    parameter int         TIMEOUT   = 1024,
    parameter int         ERR_CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_payload_function_id,
    input  logic [DATA_W-1:0] cmd_payload_inputs_0,
    input  logic [DATA_W-1:0] cmd_payload_inputs_1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_payload_outputs_0,
    output logic [6:0]        eng_cmd,
    output logic [DATA_W-1:0] eng_inp0,
    output logic [DATA_W-1:0] eng_inp1,
    output logic              eng_start,
    input  logic [DATA_W-1:0] eng_ret,
    input  logic              eng_done,
    output logic              err_sticky
);
    // Both counts run on one timer, so it is sized for the larger of the two
    localparam int MAXC = TIMEOUT > FIXED_LAT ? TIMEOUT : FIXED_LAT;
    localparam int TW   = $clog2(MAXC) + 1;

    seq_state_e           state_q, state_d;
    logic [DATA_W-1:0]    rsp_q, rsp_d, in0_q, in0_d, in1_q, in1_d;
    logic [6:0]           cmd_q, cmd_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 sticky_q, sticky_d;
    logic                 accept, is_status, is_long, expire, unused_fid;
    logic [6:0]           f7;
    logic [TW-1:0]        load_val;

    assign f7         = cmd_payload_function_id[F7_MSB:F7_LSB];
    assign unused_fid = ^cmd_payload_function_id[F7_LSB-1:0];
    assign accept     = cmd_valid && state_q == IDLE;
    assign is_status  = f7 == STATUS_F7;
    assign is_long    = cmd_q >= LONG_MIN;
    // Loading count-1 makes WAIT last exactly FIXED_LAT or TIMEOUT cycles
    assign load_val   = is_long ? TW'(TIMEOUT - 1) : TW'(FIXED_LAT - 1);

    seq_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (state_q == ISSUE),
        .load_val_i (load_val),
        .en_i       (state_q == WAIT),
        .expire_o   (expire)
    );

    // Next-state, latches and error bookkeeping
    always_comb begin
        state_d   = state_q;
        rsp_d     = rsp_q;
        cmd_d     = cmd_q;
        in0_d     = in0_q;
        in1_d     = in1_q;
        err_cnt_d = err_cnt_q;
        sticky_d  = sticky_q;
        case (state_q)
            IDLE:
                if (accept && is_status) begin
                    rsp_d    = {err_cnt_q, {(DATA_W-ERR_CNT_W-1){1'b0}}, sticky_q};
                    sticky_d = 1'b0;
                    state_d  = RESP;
                end else if (accept) begin
                    cmd_d   = f7;
                    in0_d   = cmd_payload_inputs_0;
                    in1_d   = cmd_payload_inputs_1;
                    state_d = ISSUE;
                end
            ISSUE: state_d = WAIT;
            WAIT:
                if (is_long && eng_done) begin
                    rsp_d   = eng_ret;
                    state_d = RESP;
                end else if (is_long && expire) begin
                    rsp_d     = DATA_W'(TIMEOUT_RET);
                    sticky_d  = 1'b1;
                    err_cnt_d = &err_cnt_q ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
                    state_d   = RESP;
                end else if (expire) begin
                    rsp_d   = eng_ret;
                    state_d = RESP;
                end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q   <= IDLE;
            rsp_q     <= '0;
            cmd_q     <= '0;
            in0_q     <= '0;
            in1_q     <= '0;
            err_cnt_q <= '0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_q     <= rsp_d;
            cmd_q     <= cmd_d;
            in0_q     <= in0_d;
            in1_q     <= in1_d;
            err_cnt_q <= err_cnt_d;
            sticky_q  <= sticky_d;
        end

    assign cmd_ready             = state_q == IDLE;
    assign rsp_valid             = state_q == RESP;
    assign eng_start             = state_q == ISSUE;
    assign rsp_payload_outputs_0 = rsp_q;
    assign eng_cmd               = cmd_q;
    assign eng_inp0              = in0_q;
    assign eng_inp1              = in1_q;
    assign err_sticky            = sticky_q;
endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// tb_cfu_cmd_sequencer: directed plus randomized checks against a transaction-level model
module tb_cfu_cmd_sequencer;
    localparam int FIXED_LAT = 1;
    localparam int TIMEOUT   = 16;

    logic        clk = 1'b0, reset = 1'b1;
    logic        cmd_valid = 1'b0, rsp_ready = 1'b0, eng_done = 1'b0;
    logic [9:0]  fid = '0;
    logic [31:0] in0 = '0, in1 = '0, eng_ret = '0;
    logic        cmd_ready, rsp_valid, eng_start, err_sticky;
    logic [31:0] rsp_pay, eng_inp0, eng_inp1;
    logic [6:0]  eng_cmd;

    int          tests = 0, fails = 0;
    logic [15:0] err_m = '0;
    logic        sticky_m = 1'b0;

    cfu_cmd_sequencer #(
        .DATA_W(32), .FIXED_LAT(FIXED_LAT), .LONG_MIN(7'd8), .TIMEOUT(TIMEOUT), .ERR_CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(fid),
        .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_pay),
        .eng_cmd(eng_cmd), .eng_inp0(eng_inp0), .eng_inp1(eng_inp1),
        .eng_start(eng_start), .eng_ret(eng_ret), .eng_done(eng_done),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction. done_w is the WAIT cycle (1-based) in which eng_done pulses;
    // 0 pulses it in the ISSUE cycle instead, negative never pulses it.
    task automatic run_op(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ret, input int done_w, input int hold);
        logic [31:0] exp_pay;
        int          exp_lat, lat;
        bit          is_status, is_long;
        is_status = (f7 == 7'h7F);
        is_long   = !is_status && f7 >= 7'd8;
        if (is_status) begin
            exp_pay  = {err_m, 15'd0, sticky_m};
            exp_lat  = 1;
            sticky_m = 1'b0;
        end else if (!is_long) begin
            exp_pay = ret;
            exp_lat = FIXED_LAT + 2;
        end else if (done_w >= 1 && done_w <= TIMEOUT) begin
            exp_pay = ret;
            exp_lat = done_w + 2;
        end else begin
            exp_pay  = 32'hDEAD_BEEF;
            exp_lat  = TIMEOUT + 2;
            err_m    = (err_m == 16'hFFFF) ? err_m : err_m + 16'd1;
            sticky_m = 1'b1;
        end
        @(negedge clk);
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        fid       = {f7, 3'($urandom)};
        in0       = a;
        in1       = b;
        eng_ret   = ret;
        lat       = -1;
        for (int n = 1; n <= TIMEOUT + 10; n++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            in0       = $urandom;
            in1       = $urandom;
            eng_done  = 1'b0;
            if (n == 1) begin
                check("busy_not_ready", {31'd0, cmd_ready}, 32'd0);
                check("eng_start_pulse", {31'd0, eng_start}, {31'd0, !is_status});
                if (!is_status) begin
                    check("eng_cmd", {25'd0, eng_cmd}, {25'd0, f7});
                    check("eng_inp0", eng_inp0, a);
                    check("eng_inp1", eng_inp1, b);
                end
            end
            if (n == 2 && !is_status) check("eng_start_one_cycle", {31'd0, eng_start}, 32'd0);
            if (rsp_valid) begin
                lat = n;
                break;
            end
            eng_done = is_long && (n - 1 == done_w);
        end
        eng_done = 1'b0;
        check("rsp_latency", lat, exp_lat);
        check("rsp_payload", rsp_pay, exp_pay);
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_payload", rsp_pay, exp_pay);
            check("hold_not_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("released_valid", {31'd0, rsp_valid}, 32'd0);
        check("released_ready", {31'd0, cmd_ready}, 32'd1);
        check("err_sticky", {31'd0, err_sticky}, {31'd0, sticky_m});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        err_m    = '0;
        sticky_m = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_eng_start", {31'd0, eng_start}, 32'd0);
        check("rst_payload", rsp_pay, 32'd0);
        check("rst_eng_cmd", {25'd0, eng_cmd}, 32'd0);
        check("rst_eng_inp", eng_inp0 | eng_inp1, 32'd0);
        check("rst_sticky", {31'd0, err_sticky}, 32'd0);

        run_op(7'd3, 32'd5, 32'd7, 32'd12, -1, 0);
        run_op(7'd9, 32'h11, 32'h22, 32'h0000_A5A5, 5, 0);
        run_op(7'd2, 32'h33, 32'h44, 32'h1234_5678, -1, 3);
        run_op(7'd9, 32'h55, 32'h66, 32'h0BAD_0BAD, -1, 0);
        run_op(7'h7F, 32'd0, 32'd0, 32'd0, -1, 1);
        check("status_value_literal", 32'h0001_0001, {err_m, 15'd0, 1'b1});
        run_op(7'd12, 32'h77, 32'h88, 32'hCAFE_F00D, TIMEOUT, 0);
        run_op(7'd12, 32'h99, 32'hAA, 32'h0F0F_0F0F, 0, 0);
        run_op(7'd12, 32'h99, 32'hAA, 32'h0F0F_0F0F, TIMEOUT + 1, 2);
        run_op(7'h7F, 32'd0, 32'd0, 32'd0, -1, 0);

        // Reset landing in WAIT of a long op drops the operation
        @(negedge clk);
        cmd_valid = 1'b1;
        fid       = {7'd10, 3'd0};
        eng_ret   = 32'h1111_2222;
        repeat (4) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst_sticky", {31'd0, err_sticky}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        err_m    = '0;
        sticky_m = 1'b0;
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("late_done_ignored", {31'd0, rsp_valid}, 32'd0);
        end

        // Reset during ISSUE drops eng_start without waiting for a clock
        cmd_valid = 1'b1;
        fid       = {7'd4, 3'd0};
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("issue_start_high", {31'd0, eng_start}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_start_drop", {31'd0, eng_start}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [6:0]  f;
            kind = $urandom_range(0, 3);
            f    = (kind == 0) ? 7'($urandom_range(0, 7)) :
                   (kind == 3) ? 7'h7F : 7'($urandom_range(8, 126));
            run_op(f, $urandom, $urandom, $urandom, $urandom_range(0, TIMEOUT + 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
